// File: rtl/cache_fill_fsm.sv
// Cache miss fill engine: fetches one 8-word block from pipelined memory, streams it into the data array, then commits the tag.
// Optional critical-word-first ordering is enabled by defining CACHE_FILL_CRIT_WORD_FIRST_EN.
module cache_fill_fsm #(
  parameter int WORDS_PER_BLOCK = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        miss_detected,
  input  logic [15:0] miss_address,
  input  logic        memory_data_valid,
  input  logic [15:0] memory_data,
  output logic        fsm_busy,
  output logic        mem_read_en,
  output logic [15:0] memory_address,
  output logic        write_data_array,
  output logic [2:0]  word_index,
  output logic [15:0] fill_data,
  output logic        write_tag_array
);

  localparam logic [3:0] NWORDS = 4'(WORDS_PER_BLOCK);

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

  state_t      state;
  logic [3:0]  issue_cnt;
  logic [3:0]  recv_cnt;
  logic [11:0] base_hi;
  logic [2:0]  start;
  logic [2:0]  miss_start;
  logic [2:0]  next_word;
  logic        accept;
  logic        unused_addr_bits;

  // Starting word within the block: the missed word, or word 0 for sequential fills
`ifdef CACHE_FILL_CRIT_WORD_FIRST_EN
  assign miss_start = miss_address[3:1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      start <= 3'd0;
    else if (state == IDLE && miss_detected)
      start <= miss_start;
  end
`else
  assign miss_start = 3'd0;
  assign start      = 3'd0;
`endif

  assign unused_addr_bits = ^miss_address[3:0];

  assign next_word        = start + issue_cnt[2:0] + 3'd1;
  assign accept           = (state == FILL) && memory_data_valid && (recv_cnt < NWORDS);
  assign write_data_array = accept;
  assign word_index       = accept ? (start + recv_cnt[2:0]) : 3'd0;
  assign fill_data        = accept ? memory_data : 16'd0;

  // Request outputs are registered one step ahead so each cycle presents the word issue_cnt names
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      issue_cnt       <= 4'd0;
      recv_cnt        <= 4'd0;
      base_hi         <= 12'd0;
      fsm_busy        <= 1'b0;
      mem_read_en     <= 1'b0;
      memory_address  <= 16'd0;
      write_tag_array <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (miss_detected) begin
            state          <= FILL;
            base_hi        <= miss_address[15:4];
            issue_cnt      <= 4'd0;
            recv_cnt       <= 4'd0;
            fsm_busy       <= 1'b1;
            mem_read_en    <= 1'b1;
            memory_address <= {miss_address[15:4], miss_start, 1'b0};
          end
        end
        FILL: begin
          if (issue_cnt < NWORDS) begin
            issue_cnt <= issue_cnt + 4'd1;
            if (issue_cnt < NWORDS - 4'd1)
              memory_address <= {base_hi, next_word, 1'b0};
            else
              mem_read_en <= 1'b0;
          end
          if (accept) begin
            recv_cnt <= recv_cnt + 4'd1;
            if (recv_cnt == NWORDS - 4'd1) begin
              state           <= DONE;
              write_tag_array <= 1'b1;
              mem_read_en     <= 1'b0;
            end
          end
        end
        DONE: begin
          state           <= IDLE;
          fsm_busy        <= 1'b0;
          write_tag_array <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Scoreboard bench for cache_fill_fsm: a pipelined memory model answers requests, a monitor checks
// requests, word writes and tag commits against expectations derived from the block address.
module tb_cache_fill_fsm;

  localparam int MEM_LATENCY = 4;
`ifdef CACHE_FILL_CRIT_WORD_FIRST_EN
  localparam bit CRIT = 1'b1;
`else
  localparam bit CRIT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic        memory_data_valid;
  logic [15:0] memory_data;
  logic        fsm_busy;
  logic        mem_read_en;
  logic [15:0] memory_address;
  logic        write_data_array;
  logic [2:0]  word_index;
  logic [15:0] fill_data;
  logic        write_tag_array;

  typedef struct packed {
    logic [2:0]  idx;
    logic [15:0] data;
  } wr_t;

  logic [15:0] req_q[$];
  wr_t         wr_q[$];
  int          tag_pending = 0;
  int          n_req = 0, n_wr = 0, n_tag = 0;
  int          checks = 0, failures = 0;
  logic [15:0] data_key = 16'hA000;
  bit          noise = 1'b0;

  cache_fill_fsm dut (
    .clk              (clk),
    .rst              (rst),
    .miss_detected    (miss_detected),
    .miss_address     (miss_address),
    .memory_data_valid(memory_data_valid),
    .memory_data      (memory_data),
    .fsm_busy         (fsm_busy),
    .mem_read_en      (mem_read_en),
    .memory_address   (memory_address),
    .write_data_array (write_data_array),
    .word_index       (word_index),
    .fill_data        (fill_data),
    .write_tag_array  (write_tag_array)
  );

  always #5 clk = ~clk;

  // Memory contents: each word of a block holds the current key plus its word number
  function automatic logic [15:0] mem_word(input logic [15:0] a, input logic [15:0] key);
    return key + 16'(a[3:1]);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, expected);
    end
  endtask

  task automatic reportUnexpected(input string name, input logic [31:0] actual);
    checks++;
    failures++;
    $display("[TB] FAIL %s actual=0x%0h required=no event", name, actual);
  endtask

  // Expected behaviour of one fill: 8 requests walking the block from the start word, wrapping inside it
  task automatic pushFill(input logic [15:0] a);
    int          s;
    int          w;
    logic [15:0] addr;
    wr_t         e;
    s = CRIT ? int'(a[3:1]) : 0;
    for (int k = 0; k < 8; k++) begin
      w      = (s + k) % 8;
      addr   = (a & 16'hFFF0) + 16'(w * 2);
      req_q.push_back(addr);
      e.idx  = 3'(w);
      e.data = mem_word(addr, data_key);
      wr_q.push_back(e);
    end
    tag_pending++;
  endtask

  task automatic applyStimulus(input logic [15:0] a);
    miss_address  = a;
    miss_detected = 1'b1;
    @(posedge clk);
    #1;
    miss_detected = 1'b0;
    miss_address  = 16'($urandom);
  endtask

  // Runs one fill from cycle 1, optionally holding a stray miss or resetting mid-fill, and checks the stall length
  task automatic runFill(input logic [15:0] a, input bit issue, input int inj_from, input int inj_to,
                         input logic [15:0] inj_addr, input int abort_cycle, input int exp_busy);
    int c;
    int busy_cnt;
    bit done;
    pushFill(a);
    if (issue) applyStimulus(a);
    c = 1;
    busy_cnt = 0;
    done = 1'b0;
    while (!done && c < 60) begin
      if (c >= inj_from && c <= inj_to) begin
        miss_detected = 1'b1;
        miss_address  = inj_addr;
      end
      if (c == abort_cycle) begin
        rst = 1'b0;
        req_q.delete();
        wr_q.delete();
        tag_pending = 0;
        #1;
        checkOutput("reset_ctrl", {28'd0, fsm_busy, mem_read_en, write_data_array, write_tag_array}, 32'd0);
        checkOutput("reset_addr", 32'(memory_address), 32'd0);
        checkOutput("reset_index", 32'(word_index), 32'd0);
      end
      @(negedge clk);
      if (fsm_busy) busy_cnt++;
      else done = 1'b1;
      @(posedge clk);
      #1;
      miss_detected = 1'b0;
      c++;
    end
    if (!done) reportUnexpected("busy_timeout", 32'(busy_cnt));
    checkOutput("stall_len", 32'(busy_cnt), 32'(exp_busy));
    if (abort_cycle > 0) rst = 1'b1;
  endtask

  // Lets in-flight returns drain, then pulses stray valids while idle, then checks event counts
  task automatic drainAndCheck(input int r0, input int w0, input int t0, input int dr, input int dw, input int dt);
    repeat (6) begin @(posedge clk); #1; end
    noise = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    noise = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    checkOutput("req_count", 32'(n_req - r0), 32'(dr));
    checkOutput("write_count", 32'(n_wr - w0), 32'(dw));
    checkOutput("tag_count", 32'(n_tag - t0), 32'(dt));
    checkOutput("req_q_left", 32'(req_q.size()), 32'd0);
    checkOutput("wr_q_left", 32'(wr_q.size()), 32'd0);
  endtask

  // Pipelined memory: a request seen in cycle c returns valid data in cycle c+MEM_LATENCY
  initial begin
    logic [MEM_LATENCY-1:0] pv;
    logic [15:0]            pa[MEM_LATENCY];
    logic                   cur_en;
    logic [15:0]            cur_a;
    pv = '0;
    for (int i = 0; i < MEM_LATENCY; i++) pa[i] = 16'd0;
    memory_data_valid = 1'b0;
    memory_data       = 16'd0;
    forever begin
      @(negedge clk);
      cur_en = mem_read_en;
      cur_a  = memory_address;
      @(posedge clk);
      #1;
      pv = {pv[MEM_LATENCY-2:0], cur_en};
      for (int i = MEM_LATENCY - 1; i > 0; i--) pa[i] = pa[i-1];
      pa[0] = cur_a;
      memory_data_valid = pv[MEM_LATENCY-1] | noise;
      memory_data = pv[MEM_LATENCY-1] ? mem_word(pa[MEM_LATENCY-1], data_key) : 16'($urandom);
    end
  end

  // Monitor: every strobe the DUT presents must match the head of its expectation queue
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (mem_read_en) begin
          n_req++;
          if (req_q.size() == 0) reportUnexpected("unexpected_req", 32'(memory_address));
          else checkOutput("req_addr", 32'(memory_address), 32'(req_q.pop_front()));
        end
        if (write_data_array) begin
          n_wr++;
          if (wr_q.size() == 0) reportUnexpected("unexpected_write", 32'(fill_data));
          else begin
            e = wr_q.pop_front();
            checkOutput("word_index", 32'(word_index), 32'(e.idx));
            checkOutput("fill_data", 32'(fill_data), 32'(e.data));
          end
        end
        if (write_tag_array) begin
          n_tag++;
          if (tag_pending == 0) reportUnexpected("unexpected_tag", 32'd1);
          else begin
            tag_pending--;
            checkOutput("busy_at_tag", 32'(fsm_busy), 32'd1);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          r0, w0, t0;
    logic [15:0] a;
    miss_detected = 1'b0;
    miss_address  = 16'd0;

    #2 rst = 1'b0;
    #1;
    checkOutput("async_reset_ctrl", {28'd0, fsm_busy, mem_read_en, write_data_array, write_tag_array}, 32'd0);
    checkOutput("async_reset_addr", 32'(memory_address), 32'd0);
    checkOutput("async_reset_index", 32'(word_index), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    noise = 1'b1;
    repeat (10) begin
      @(negedge clk);
      checkOutput("idle_busy", 32'(fsm_busy), 32'd0);
      checkOutput("idle_read", 32'(mem_read_en), 32'd0);
    end
    @(posedge clk);
    #1 noise = 1'b0;
    repeat (6) begin @(posedge clk); #1; end

    $display("[TB] basic fill 0x1236");
    data_key = 16'hA000;
    r0 = n_req; w0 = n_wr; t0 = n_tag;
    runFill(16'h1236, 1'b1, 0, 0, 16'h0, 0, 13);
    drainAndCheck(r0, w0, t0, 8, 8, 1);

    $display("[TB] miss during fill");
    data_key = 16'($urandom);
    r0 = n_req; w0 = n_wr; t0 = n_tag;
    runFill(16'h1230, 1'b1, 3, 3, 16'h4000, 0, 13);
    drainAndCheck(r0, w0, t0, 8, 8, 1);

    $display("[TB] top-of-memory block");
    data_key = 16'($urandom);
    r0 = n_req; w0 = n_wr; t0 = n_tag;
    runFill(16'hFFFE, 1'b1, 0, 0, 16'h0, 0, 13);
    drainAndCheck(r0, w0, t0, 8, 8, 1);

    $display("[TB] reset mid-fill then refill");
    data_key = 16'($urandom);
    r0 = n_req; w0 = n_wr; t0 = n_tag;
    runFill(16'h1230, 1'b1, 0, 0, 16'h0, 7, 6);
    drainAndCheck(r0, w0, t0, 6, 2, 0);
    r0 = n_req; w0 = n_wr; t0 = n_tag;
    runFill(16'h0040, 1'b1, 0, 0, 16'h0, 0, 13);
    drainAndCheck(r0, w0, t0, 8, 8, 1);

    $display("[TB] miss held through DONE is taken one idle cycle later");
    data_key = 16'($urandom);
    a = 16'($urandom);
    r0 = n_req; w0 = n_wr; t0 = n_tag;
    runFill(16'h2468, 1'b1, 12, 14, a, 0, 13);
    runFill(a, 1'b0, 0, 0, 16'h0, 0, 13);
    drainAndCheck(r0, w0, t0, 16, 16, 2);

    $display("[TB] random fills");
    for (int i = 0; i < 6; i++) begin
      data_key = 16'($urandom);
      a = 16'($urandom);
      r0 = n_req; w0 = n_wr; t0 = n_tag;
      runFill(a, 1'b1, int'($urandom_range(2, 13)), 0, 16'($urandom), 0, 13);
      drainAndCheck(r0, w0, t0, 8, 8, 1);
    end

    checkOutput("tag_pending_left", 32'(tag_pending), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
